// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues single-outstanding word fetches over a
// valid/ready port and presents the fetched instruction with pre-split decode fields.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pcloadEn,
  input  logic [31:0] pc_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        fetch_fault
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] instr_n, instr_pc_n;
  logic            discard, discard_n;
  logic            instr_valid_n, fetch_fault_n;
  logic            accept, redirect_ok, redirect_bad;

  assign accept       = (state == S_REQ) && imem_ready;
  assign redirect_bad = pcloadEn && (pc_target[1:0] != 2'b00);
  assign redirect_ok  = pcloadEn && (pc_target[1:0] == 2'b00);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      discard     <= 1'b0;
      instr       <= NOP;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      discard     <= discard_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      fetch_fault <= fetch_fault_n;
    end
  end

  // Next-state logic; redirects outrank stall, a misaligned target is terminal
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    discard_n     = discard;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    fetch_fault_n = fetch_fault;

    if ((state != S_FAULT) && redirect_bad) begin
      state_n       = S_FAULT;
      fetch_fault_n = 1'b1;
      instr_valid_n = 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_ok) begin
            pc_n = pc_target;
            if (accept) begin
              discard_n = 1'b1;
              state_n   = S_WAIT;
            end
          end else if (accept) begin
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_ok) begin
            pc_n = pc_target;
            // A response landing with the redirect is already stale
            if (imem_rvalid) begin
              discard_n = 1'b0;
              state_n   = S_REQ;
            end else begin
              discard_n = 1'b1;
            end
          end else if (imem_rvalid) begin
            if (discard) begin
              discard_n = 1'b0;
              state_n   = S_REQ;
            end else begin
              instr_n       = imem_rdata;
              instr_pc_n    = pc;
              instr_valid_n = 1'b1;
              state_n       = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_ok) begin
            pc_n          = pc_target;
            instr_valid_n = 1'b0;
            state_n       = S_REQ;
          end else if (!stall) begin
            pc_n          = pc + XLEN'(4);
            instr_valid_n = 1'b0;
            state_n       = S_REQ;
          end
        end
        S_FAULT: begin
          state_n = S_FAULT;
        end
        default: begin
          state_n = S_REQ;
        end
      endcase
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign pc_plus4  = instr_pc + XLEN'(4);

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign func3  = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign func7  = instr[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: scripted memory responses, hand-computed expectations.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pcloadEn;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .pcloadEn(pcloadEn), .pc_target(pc_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .opcode(opcode), .func3(func3), .func7(func7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are settled and inputs may be changed afterwards
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stall = 1'b0; pcloadEn = 1'b0; pc_target = '0;
    tick(); tick();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    rst = 1'b0;

    // 1: two back-to-back fetches, 1-cycle latency
    imem_ready = 1'b1;
    chk("t1_req0", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick();
    chk("t1_wait_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_opcode", 32'(opcode), 32'h13);
    chk("t1_rd", 32'(rd), 32'd1);
    chk("t1_rs1", 32'(rs1), 32'd0);
    chk("t1_rs2", 32'(rs2), 32'd5);
    chk("t1_func3", 32'(func3), 32'd0);
    chk("t1_func7", 32'(func7), 32'd0);
    chk("t1_ipc", instr_pc, 32'h0);
    chk("t1_pc4", pc_plus4, 32'h4);
    tick();
    chk("t1_req4", 32'(imem_req), 32'd1);
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_novalid", 32'(instr_valid), 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0;
    chk("t1_instr2", instr, 32'h00A0_0113);
    chk("t1_rd2", 32'(rd), 32'd2);
    chk("t1_ipc2", instr_pc, 32'h4);
    chk("t1_pc4_2", pc_plus4, 32'h8);

    // 2: stall holds the instruction at PC 4
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_instr", instr, 32'h00A0_0113);
      chk("t2_ipc", instr_pc, 32'h4);
      chk("t2_req", 32'(imem_req), 32'd0);
      chk("t2_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("t2_req8", 32'(imem_req), 32'd1);
    chk("t2_addr8", imem_addr, 32'h8);

    // 3: redirect while waiting on addr 8; late response must be dropped
    tick();
    chk("t3_wait", 32'(imem_req), 32'd0);
    pcloadEn = 1'b1; pc_target = 32'h100; imem_ready = 1'b0;
    tick();
    pcloadEn = 1'b0;
    tick(); tick();
    chk("t3_noreq", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("t3_valid", 32'(instr_valid), 32'd0);
    chk("t3_instr", instr, 32'h00A0_0113);
    chk("t3_req", 32'(imem_req), 32'd1);
    chk("t3_addr", imem_addr, 32'h100);
    tick();
    chk("t3_valid2", 32'(instr_valid), 32'd0);

    // REQ redirect without accept: new address next cycle, still requesting
    pcloadEn = 1'b1; pc_target = 32'hC;
    tick();
    pcloadEn = 1'b0;
    chk("t3b_req", 32'(imem_req), 32'd1);
    chk("t3b_addr", imem_addr, 32'hC);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00C0_0193;
    tick();
    imem_rvalid = 1'b0;
    chk("t4_ipc", instr_pc, 32'hC);
    chk("t4_rd", 32'(rd), 32'd3);

    // 4: redirect and stall together in HOLD, redirect wins
    pcloadEn = 1'b1; stall = 1'b1; pc_target = 32'h40;
    tick();
    pcloadEn = 1'b0; stall = 1'b0;
    chk("t4_valid", 32'(instr_valid), 32'd0);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h40);

    // 5: ready low for 4 cycles at addr 0x20
    pcloadEn = 1'b1; pc_target = 32'h20;
    tick();
    pcloadEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_req", 32'(imem_req), 32'd1);
      chk("t5_addr", imem_addr, 32'h20);
      tick();
    end
    imem_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("t5_one", 32'(imem_req), 32'd0);
      tick();
    end
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0293;
    tick();
    imem_rvalid = 1'b0;
    chk("t5_ipc", instr_pc, 32'h20);
    chk("t5_rd", 32'(rd), 32'd5);
    chk("t5_pc4", pc_plus4, 32'h24);

    // Redirect in the same cycle the request is accepted: response dropped
    tick();
    chk("t5b_addr", imem_addr, 32'h24);
    imem_ready = 1'b1; pcloadEn = 1'b1; pc_target = 32'h80;
    tick();
    imem_ready = 1'b0; pcloadEn = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0013;
    tick();
    imem_rvalid = 1'b0;
    chk("t5b_valid", 32'(instr_valid), 32'd0);
    chk("t5b_instr", instr, 32'h0010_0293);
    chk("t5b_addr2", imem_addr, 32'h80);

    // Address wrap at the top of memory
    pcloadEn = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick();
    pcloadEn = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_rvalid = 1'b0;
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);

    // 6a: misaligned redirect is terminal
    pcloadEn = 1'b1; pc_target = 32'h102;
    tick();
    pcloadEn = 1'b0; imem_ready = 1'b1;
    chk("t6_fault", 32'(fetch_fault), 32'd1);
    chk("t6_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_noreq", 32'(imem_req), 32'd0);
    end
    imem_rvalid = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    chk("t6_valid2", 32'(instr_valid), 32'd0);
    chk("t6_fault2", 32'(fetch_fault), 32'd1);

    // 6b: asynchronous reset mid-WAIT, late response ignored
    rst = 1'b1;
    #1;
    chk("t6b_fault", 32'(fetch_fault), 32'd0);
    chk("t6b_req", 32'(imem_req), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    imem_ready = 1'b0;
    chk("t6b_wait", 32'(imem_req), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6b_req2", 32'(imem_req), 32'd1);
    chk("t6b_addr2", imem_addr, 32'h0);
    chk("t6b_valid", 32'(instr_valid), 32'd0);
    tick();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("t6b_ign_valid", 32'(instr_valid), 32'd0);
    chk("t6b_ign_instr", instr, 32'h0000_0013);
    chk("t6b_req3", 32'(imem_req), 32'd1);
    chk("t6b_addr3", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
